// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the SPI shifter arbiter.
// Covers the FSM state encoding, the one-hot target codes and the requester indices.
package spi_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } arb_state_e;

    localparam logic [2:0] TGT_FLASH = 3'b001;
    localparam logic [2:0] TGT_LED1  = 3'b010;
    localparam logic [2:0] TGT_LED2  = 3'b100;

    localparam int REQ_CPU   = 0;
    localparam int REQ_LED   = 1;
    localparam int REQ_FLASH = 2;

    function automatic logic is_onehot3(input logic [2:0] t);
        return (t == TGT_FLASH) || (t == TGT_LED1) || (t == TGT_LED2);
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Combinational round-robin selector: scans req starting one past rr_ptr
// and returns the first set requester as one-hot plus its index.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic [PTR_W-1:0] win_idx,
    output logic             valid
);

    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_idx = '0;
        valid   = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (!valid && req[idx]) begin
                valid        = 1'b1;
                win[idx]     = 1'b1;
                win_idx      = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one 8-bit SPI shifter between N_REQ requesters, granting whole bursts
// round-robin and sequencing the chip selects around each burst.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 1
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   tgt,
    input  logic [8*N_REQ-1:0]   tx_data,
    input  logic [N_REQ-1:0]     tx_last,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           rx_data,
    output logic [N_REQ-1:0]     rx_valid,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     err,
    output logic [2:0]           cs_b,
    output logic                 sh_start,
    output logic [2:0]           sh_sel,
    output logic [7:0]           sh_tx,
    input  logic [7:0]           sh_rx,
    input  logic                 sh_done,
    output logic                 busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state, state_nx, hold_nx;
    logic [3:0]       cnt;
    logic [PTR_W-1:0] rr_ptr, own;
    logic             last_flag, pend;

    logic [N_REQ-1:0] pick;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_vld;
    logic [2:0]       pick_tgt;

    logic do_grant, do_err, do_shift, do_release, done_fire, burst_end;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win     (pick),
        .win_idx (pick_idx),
        .valid   (pick_vld)
    );

    assign pick_tgt   = tgt[3*int'(pick_idx) +: 3];
    assign done_fire  = (state == WAIT) && !pend && sh_done;
    assign burst_end  = last_flag || !req[own];
    assign busy       = (state != IDLE);
    assign do_shift   = (state_nx == SHIFT);
    assign do_release = (state_nx == GAP) && (state != GAP);

    // The sh_done edge already counts toward CS_HOLD, so a hold of 1 skips HOLD entirely.
    always_comb begin
        hold_nx = (CS_HOLD == 1) ? GAP : HOLD;
    end

    always_comb begin
        state_nx = state;
        do_grant = 1'b0;
        do_err   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    if (is_onehot3(pick_tgt)) begin
                        do_grant = 1'b1;
                        state_nx = SETUP;
                    end else begin
                        do_err = 1'b1;
                    end
                end
            end
            SETUP: if (cnt == 4'(CS_SETUP - 1)) state_nx = SHIFT;
            SHIFT: state_nx = WAIT;
            // pend marks the spacer cycle between a byte's sh_done and the next sh_start
            WAIT: begin
                if (pend)
                    state_nx = req[own] ? SHIFT : hold_nx;
                else if (sh_done && burst_end)
                    state_nx = hold_nx;
            end
            HOLD:    if (cnt == 4'(CS_HOLD - 1)) state_nx = GAP;
            GAP:     if (cnt == 4'(CS_GAP - 1))  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= PTR_W'(N_REQ - 1);
            own       <= '0;
            last_flag <= 1'b0;
            pend      <= 1'b0;
            grant     <= '0;
            cs_b      <= 3'b111;
            sh_sel    <= '0;
            sh_start  <= 1'b0;
            sh_tx     <= '0;
            ack       <= '0;
            err       <= '0;
            rx_valid  <= '0;
            rx_data   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                cnt <= (state_nx == HOLD) ? 4'd1 : 4'd0;
            else
                cnt <= cnt + 4'd1;

            err <= do_err ? pick : '0;
            if (do_err)
                rr_ptr <= pick_idx;

            if (do_grant) begin
                rr_ptr <= pick_idx;
                own    <= pick_idx;
                grant  <= pick;
                cs_b   <= ~pick_tgt;
                sh_sel <= pick_tgt;
            end

            sh_start <= do_shift;
            ack      <= do_shift ? grant : '0;
            if (do_shift) begin
                sh_tx     <= tx_data[8*int'(own) +: 8];
                last_flag <= tx_last[own];
            end

            pend     <= done_fire && !burst_end;
            rx_valid <= done_fire ? grant : '0;
            if (done_fire)
                rx_data <= sh_rx;

            if (do_release) begin
                grant  <= '0;
                cs_b   <= 3'b111;
                sh_sel <= '0;
            end
        end
    end

endmodule
